// File: rtl/tapped_ring_meter_if.sv
// Control/result bundle of the tapped ring meter: the requester drives start and the
// measurement setup; the meter returns busy/done and the held result.
interface tapped_ring_meter_if #(
  parameter int unsigned TAPS  = 8,
  parameter int unsigned WIN_W = 16,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned TAP_W = $clog2(TAPS);

  logic             start;
  logic [TAP_W-1:0] tap;
  logic             sel_ext;
  logic [WIN_W-1:0] window;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start, tap, sel_ext, window,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, tap, sel_ext, window,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/tapped_ring_meter.sv
// Gated odd-length tapped inverter ring plus a single-clock meter that counts synchronised
// rising edges of the ring (or ext_osc) over a programmable window of clk cycles.
module tapped_ring_meter #(
  parameter int unsigned BASE_LEN   = 1000,
  parameter int unsigned STEP_LEN   = 100,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  tapped_ring_meter_if.slave bus,
  input  logic               ext_osc,
  output logic               ring_out
);
  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_e;

  state_e           state_q;
  logic             ring_en_q;
  logic [TAP_W-1:0] tap_q;
  logic             sel_ext_q;
  logic [WIN_W-1:0] window_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;
  logic             s1_q, s2_q, s3_q;

  logic [TAPS-1:0]  taps;
  logic             ring_close;
  logic             src;
  logic             rise;
  logic [TAP_W-1:0] tap_clamped;

  // ---------------------------------------------------------------------------------------
  // Ring: start inverter -> seg0 (BASE_LEN) -> seg1..segN (STEP_LEN each). Every segment is
  // even, so the loop through any tap is odd and oscillates while ring_en_q is high.
  // ---------------------------------------------------------------------------------------
  (* keep = "true" *) logic start_inv;

  assign ring_close = taps[tap_q] & ring_en_q;
  assign start_inv  = ~ring_close;

  for (genvar k = 0; k < TAPS; k++) begin : g_seg
    localparam int unsigned Len = (k == 0) ? BASE_LEN : STEP_LEN;

    (* keep = "true" *) logic [Len:0] node;

    if (k == 0) begin : g_in_start
      assign node[0] = start_inv;
    end else begin : g_in_prev
      assign node[0] = taps[k-1];
    end

    for (genvar i = 0; i < Len; i++) begin : g_inv
      (* keep_hierarchy = "yes" *) logic inv_out;
      assign inv_out    = ~node[i];
      assign node[i+1]  = inv_out;
    end

    assign taps[k] = node[Len];
  end

  assign ring_out = taps[tap_q];

  // ---------------------------------------------------------------------------------------
  // Source selection and edge detection
  // ---------------------------------------------------------------------------------------
  assign src  = sel_ext_q ? ext_osc : ring_out;
  assign rise = s2_q & ~s3_q;

  always_comb begin
    tap_clamped = bus.tap;
    if (32'(bus.tap) >= TAPS) begin
      tap_clamped = TAP_W'(TAPS - 1);
    end
  end

  // ---------------------------------------------------------------------------------------
  // Measurement FSM with registered outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ring_en_q    <= 1'b0;
      tap_q        <= '0;
      sel_ext_q    <= 1'b0;
      window_q     <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
    end else begin
      s1_q <= src;
      s2_q <= s1_q;
      s3_q <= s2_q;

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            tap_q      <= tap_clamped;
            sel_ext_q  <= bus.sel_ext;
            window_q   <= bus.window;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            // A zero window enters DONE with done_q low; the pulse follows one cycle later.
            if (bus.window == '0) begin
              state_q <= StDone;
            end else begin
              state_q      <= StSettle;
              ring_en_q    <= ~bus.sel_ext;
              settle_cnt_q <= SET_W'(SETTLE_CYC - 1);
            end
          end
        end

        StSettle: begin
          if (settle_cnt_q == '0) begin
            state_q   <= StMeasure;
            win_cnt_q <= window_q - 1'b1;
          end else begin
            settle_cnt_q <= settle_cnt_q - 1'b1;
          end
        end

        StMeasure: begin
          if (rise) begin
            if (&count_q) begin
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
          if (win_cnt_q == '0) begin
            state_q   <= StDone;
            ring_en_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            win_cnt_q <= win_cnt_q - 1'b1;
          end
        end

        StDone: begin
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule
